// File: rtl/regfile_seq.sv
// Multi-cycle IDLE/READ/EXEC/WB sequencer driving a registered-read register file and a combinational ALU.
// Define REGFILE_SEQ_IMM_EN to execute immediate forms; otherwise ops 1..E retire as illegal.
module regfile_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] inst,
    input  logic        inst_valid,
    output logic        inst_ready,
    output logic [3:0]  rf_dst_addr,
    output logic [3:0]  rf_src_addr,
    input  logic [15:0] rf_dst_data,
    input  logic [15:0] rf_src_data,
    output logic        rf_write,
    output logic [15:0] rf_wdata,
    output logic [3:0]  alu_op,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    input  logic [15:0] alu_result,
    input  logic [2:0]  alu_flags,
    output logic [2:0]  flags,
    output logic        done,
    output logic        illegal
);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [15:0] r_inst;
    logic [15:0] r_result;
    logic [2:0]  r_flags;

    logic [3:0]  w_op;
    logic [3:0]  w_rd;
    logic [3:0]  w_ext;
    logic [3:0]  w_rs;
    logic        w_is_rr;
    logic        w_is_nop;
    logic        w_exec;
    logic        w_illegal;
    logic        w_writes;
    logic [3:0]  w_eff_op;
    logic [3:0]  w_src_addr;
    logic [15:0] w_b_operand;

    assign w_op     = r_inst[15:12];
    assign w_rd     = r_inst[11:8];
    assign w_ext    = r_inst[7:4];
    assign w_rs     = r_inst[3:0];
    assign w_is_rr  = (w_op == 4'h0);
    assign w_is_nop = (w_op == 4'hF);
    assign w_eff_op = w_is_rr ? w_ext : w_op;
    // Immediate forms never read a source register, so the src port is parked at R0.
    assign w_src_addr = w_is_rr ? w_rs : 4'h0;

`ifdef REGFILE_SEQ_IMM_EN
    assign w_exec      = !w_is_nop;
    assign w_illegal   = 1'b0;
    assign w_b_operand = w_is_rr ? rf_src_data : {{8{r_inst[7]}}, r_inst[7:0]};
`else
    assign w_exec      = w_is_rr;
    assign w_illegal   = !w_is_rr && !w_is_nop;
    assign w_b_operand = rf_src_data;
`endif

    // Compare only sets flags; every other executed op writes its result back.
    assign w_writes = w_exec && (w_eff_op != 4'hB);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_inst   <= 16'h0000;
            r_result <= 16'h0000;
            r_flags  <= 3'b000;
        end else begin
            r_state <= w_state_next;
            if (r_state == S_IDLE && inst_valid) begin
                r_inst <= inst;
            end
            if (r_state == S_EXEC && w_exec) begin
                r_result <= alu_result;
                r_flags  <= alu_flags;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (inst_valid) w_state_next = S_READ;
            S_READ:  w_state_next = S_EXEC;
            S_EXEC:  w_state_next = S_WB;
            S_WB:    w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Outputs are forced low during reset so a reset in WB cannot leak a write or done.
    always_comb begin
        inst_ready  = 1'b0;
        rf_dst_addr = 4'h0;
        rf_src_addr = 4'h0;
        rf_write    = 1'b0;
        rf_wdata    = 16'h0000;
        alu_op      = 4'h0;
        alu_a       = 16'h0000;
        alu_b       = 16'h0000;
        done        = 1'b0;
        illegal     = 1'b0;
        if (!rst) begin
            case (r_state)
                S_IDLE: inst_ready = 1'b1;
                S_READ: begin
                    rf_dst_addr = w_rd;
                    rf_src_addr = w_src_addr;
                end
                S_EXEC: begin
                    rf_dst_addr = w_rd;
                    rf_src_addr = w_src_addr;
                    if (w_exec) begin
                        alu_op = w_eff_op;
                        alu_a  = rf_dst_data;
                        alu_b  = w_b_operand;
                    end
                end
                S_WB: begin
                    rf_dst_addr = w_rd;
                    rf_src_addr = w_src_addr;
                    rf_write    = w_writes;
                    rf_wdata    = r_result;
                    done        = 1'b1;
                    illegal     = w_illegal;
                end
                default: inst_ready = 1'b0;
            endcase
        end
    end

    assign flags = r_flags;

endmodule

// File: tb/tb_regfile_seq.sv
// Bench for regfile_seq: bench-side register file and ALU, an instruction-level model, and a per-cycle compare.
module tb_regfile_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] inst;
    logic        inst_valid;
    logic        inst_ready;
    logic [3:0]  rf_dst_addr;
    logic [3:0]  rf_src_addr;
    logic [15:0] rf_dst_data;
    logic [15:0] rf_src_data;
    logic        rf_write;
    logic [15:0] rf_wdata;
    logic [3:0]  alu_op;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [15:0] alu_result;
    logic [2:0]  alu_flags;
    logic [2:0]  flags;
    logic        done;
    logic        illegal;

    always #5 clk = ~clk;

    regfile_seq dut (
        .clk        (clk),
        .rst        (rst),
        .inst       (inst),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .rf_dst_addr(rf_dst_addr),
        .rf_src_addr(rf_src_addr),
        .rf_dst_data(rf_dst_data),
        .rf_src_data(rf_src_data),
        .rf_write   (rf_write),
        .rf_wdata   (rf_wdata),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result),
        .alu_flags  (alu_flags),
        .flags      (flags),
        .done       (done),
        .illegal    (illegal)
    );

`ifdef REGFILE_SEQ_IMM_EN
    localparam bit IMM_EN = 1'b1;
`else
    localparam bit IMM_EN = 1'b0;
`endif

    function automatic logic [15:0] init_val(input int i);
        case (i)
            1: return 16'd5;
            2: return 16'd7;
            3: return 16'd4;
            4: return 16'd2;
            default: return 16'h1000 + 16'(i);
        endcase
    endfunction

    // Returns {C, N, Z, result}; C is carry for add and borrow for sub/compare.
    function automatic logic [18:0] alu_model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [16:0] t;
        logic [15:0] r;
        logic        c;
        t = 17'h0;
        c = 1'b0;
        case (op)
            4'h1: r = a & b;
            4'h2: r = a | b;
            4'h3: r = a ^ b;
            4'h5: begin t = {1'b0, a} + {1'b0, b}; r = t[15:0]; c = t[16]; end
            4'h9, 4'hB: begin t = {1'b0, a} - {1'b0, b}; r = t[15:0]; c = t[16]; end
            4'hD: r = b;
            default: r = a;
        endcase
        return {c, r[15], (r == 16'h0), r};
    endfunction

    assign {alu_flags, alu_result} = alu_model(alu_op, alu_a, alu_b);

    logic [15:0] rf [16];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) rf[i] <= init_val(i);
            rf_dst_data <= 16'h0;
            rf_src_data <= 16'h0;
        end else begin
            rf_dst_data <= rf[rf_dst_addr];
            rf_src_data <= rf[rf_src_addr];
            if (rf_write) rf[rf_dst_addr] <= rf_wdata;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Instruction-level model: an accepted instruction retires 3 cycles later.
    bit          m_active = 1'b0;
    int          m_k = 0;
    logic [3:0]  m_rd, m_src, m_eff;
    bit          m_exec, m_wr, m_ill;
    logic [15:0] m_a, m_b, m_res;
    logic [2:0]  m_rflags;
    logic [2:0]  m_flags = 3'b000;
    logic [15:0] m_reg [16];
    int          cyc = 0;
    int          m_accepts = 0;
    int          acc_q[$];
    logic [3:0]  d_op;
    bit          d_rr, d_nop;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_active = 1'b0;
            m_flags  = 3'b000;
            for (int i = 0; i < 16; i++) m_reg[i] = init_val(i);
        end else if (m_active) begin
            if (m_k == 2 && m_exec) m_flags = m_rflags;
            if (m_k == 3) begin
                if (m_wr) m_reg[m_rd] = m_res;
                m_active = 1'b0;
            end else begin
                m_k++;
            end
        end else if (inst_valid) begin
            d_op   = inst[15:12];
            d_rr   = (d_op == 4'h0);
            d_nop  = (d_op == 4'hF);
            m_exec = d_rr || (!d_nop && IMM_EN);
            m_ill  = !d_rr && !d_nop && !IMM_EN;
            m_eff  = d_rr ? inst[7:4] : d_op;
            m_rd   = inst[11:8];
            m_src  = d_rr ? inst[3:0] : 4'h0;
            m_a    = m_reg[inst[11:8]];
            m_b    = d_rr ? m_reg[inst[3:0]] : 16'($signed(inst[7:0]));
            {m_rflags, m_res} = alu_model(m_eff, m_a, m_b);
            m_wr   = m_exec && (m_eff != 4'hB);
            m_active = 1'b1;
            m_k = 1;
            m_accepts++;
            acc_q.push_back(cyc);
        end
    end

    int          n_done = 0;
    int          n_ill = 0;
    int          n_wr = 0;
    logic [15:0] seen_alu_b = 16'h0;
    logic        e_ready, e_write, e_done, e_ill;
    logic [3:0]  e_dst, e_src, e_op;
    logic [15:0] e_a, e_b;

    always @(negedge clk) begin
        e_ready = !rst && !m_active;
        e_dst = 4'h0; e_src = 4'h0; e_op = 4'h0; e_a = 16'h0; e_b = 16'h0;
        e_write = 1'b0; e_done = 1'b0; e_ill = 1'b0;
        if (!rst && m_active) begin
            e_dst = m_rd;
            e_src = m_src;
            if (m_k == 2 && m_exec) begin
                e_op = m_eff; e_a = m_a; e_b = m_b;
                seen_alu_b = alu_b;
            end
            if (m_k == 3) begin
                e_write = m_wr; e_done = 1'b1; e_ill = m_ill;
            end
        end
        chk("inst_ready", 32'(inst_ready), 32'(e_ready));
        chk("rf_dst_addr", 32'(rf_dst_addr), 32'(e_dst));
        chk("rf_src_addr", 32'(rf_src_addr), 32'(e_src));
        chk("alu_op", 32'(alu_op), 32'(e_op));
        chk("alu_a", 32'(alu_a), 32'(e_a));
        chk("alu_b", 32'(alu_b), 32'(e_b));
        chk("rf_write", 32'(rf_write), 32'(e_write));
        chk("done", 32'(done), 32'(e_done));
        chk("illegal", 32'(illegal), 32'(e_ill));
        chk("flags", 32'(flags), 32'(m_flags));
        if (e_write) chk("rf_wdata", 32'(rf_wdata), 32'(m_res));
        if (done === 1'b1) n_done++;
        if (illegal === 1'b1) n_ill++;
        if (rf_write === 1'b1) n_wr++;
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [15:0] w);
        int a0, d0, t;
        a0 = m_accepts;
        d0 = n_done;
        inst = w;
        inst_valid = 1'b1;
        t = 0;
        while (m_accepts == a0 && t < 10) begin step(); t++; end
        inst_valid = 1'b0;
        inst = 16'h5A5A;
        chk("accepted", 32'(m_accepts - a0), 32'd1);
        t = 0;
        while (n_done == d0 && t < 10) begin step(); t++; end
        chk("retired", 32'(n_done - d0), 32'd1);
    endtask

    logic [15:0] tbl [9];
    int a0, d0, w0, i0, t;

    initial begin
        rst = 1'b1; inst_valid = 1'b0; inst = 16'h0;
        tbl[0] = 16'h0152; tbl[1] = 16'h0551; tbl[2] = 16'h0552; tbl[3] = 16'hF000;
        tbl[4] = 16'h0213; tbl[5] = 16'h0551; tbl[6] = 16'h05B5; tbl[7] = 16'h0559;
        tbl[8] = 16'h0391;
        repeat (3) step();
        rst = 1'b0;
        repeat (5) step();
        chk("idle_ready", 32'(inst_ready), 32'd1);
        chk("reset_flags", 32'(flags), 32'd0);

        send(16'h0152);
        chk("add_r1", 32'(rf[1]), 32'd12);
        chk("add_flags", 32'(flags), 32'd0);

        send(16'h03B3);
        chk("cmp_flags", 32'(flags), 32'b001);
        chk("cmp_r3_kept", 32'(rf[3]), 32'd4);

        i0 = n_ill;
        send(16'h54FF);
`ifdef REGFILE_SEQ_IMM_EN
        chk("imm_alu_b", 32'(seen_alu_b), 32'h0000FFFF);
        chk("imm_r4", 32'(rf[4]), 32'd1);
        chk("imm_flags", 32'(flags), 32'b100);
`else
        chk("imm_illegal", 32'(n_ill - i0), 32'd1);
        chk("imm_r4_kept", 32'(rf[4]), 32'd2);
        chk("imm_flags_kept", 32'(flags), 32'b001);
`endif

        // Valid held high while the word changes every cycle: only every 4th word is taken.
        a0 = m_accepts; d0 = n_done;
        acc_q.delete();
        inst_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            inst = tbl[i];
            step();
        end
        inst_valid = 1'b0;
        t = 0;
        while (n_done - d0 < 3 && t < 20) begin step(); t++; end
        chk("b2b_accepts", 32'(m_accepts - a0), 32'd3);
        chk("b2b_retired", 32'(n_done - d0), 32'd3);
        if (acc_q.size() == 3) begin
            chk("b2b_gap1", 32'(acc_q[1] - acc_q[0]), 32'd4);
            chk("b2b_gap2", 32'(acc_q[2] - acc_q[1]), 32'd4);
        end
        chk("b2b_r1", 32'(rf[1]), 32'd19);
        chk("b2b_r2", 32'(rf[2]), 32'd4);
        chk("b2b_r3", 32'(rf[3]), 32'h0000FFF1);
        chk("b2b_r5_ignored", 32'(rf[5]), 32'h00001005);
        chk("b2b_flags", 32'(flags), 32'b110);

        // Reset while a write instruction sits in EXEC.
        a0 = m_accepts;
        inst = 16'h0152; inst_valid = 1'b1;
        step();
        inst_valid = 1'b0;
        chk("rst_test_accept", 32'(m_accepts - a0), 32'd1);
        step();
        d0 = n_done; w0 = n_wr;
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        chk("rst_ready", 32'(inst_ready), 32'd1);
        chk("rst_flags", 32'(flags), 32'd0);
        repeat (3) step();
        chk("rst_no_done", 32'(n_done - d0), 32'd0);
        chk("rst_no_write", 32'(n_wr - w0), 32'd0);

        // Reset and valid together: nothing is taken.
        rst = 1'b1; inst_valid = 1'b1; inst = 16'h0152;
        step();
        rst = 1'b0; inst_valid = 1'b0;
        step();
        chk("rst_wins", 32'(inst_ready), 32'd1);

        w0 = n_wr;
        send(16'hF123);
        chk("nop_no_write", 32'(n_wr - w0), 32'd0);
        repeat (2) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
